// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel frame collector.
package pixel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } t_collector_state;

  localparam int DIM_W      = 12;
  localparam int COUNT_W    = 2 * DIM_W;
  localparam int CHECKSUM_W = 32;

  // Order-sensitive mix: rotate left by one, then fold in the new pixel.
  function automatic logic [CHECKSUM_W-1:0] checksum_step(
    input logic [CHECKSUM_W-1:0] sum,
    input logic [CHECKSUM_W-1:0] pixel
  );
    return {sum[CHECKSUM_W-2:0], sum[CHECKSUM_W-1]} ^ pixel;
  endfunction

endpackage

// File: rtl/pixel_frame_collector_if.sv
// Stream, geometry and status bundle between a pixel source and the collector.
interface pixel_frame_collector_if #(
  parameter int PIXEL_W = 8,
  parameter int DIM_W   = pixel_pkg::DIM_W
);

  logic                 start;
  logic [DIM_W-1:0]     size_x;
  logic [DIM_W-1:0]     size_y;
  logic [PIXEL_W-1:0]   pixel_in;
  logic                 pixel_valid;

  logic [DIM_W-1:0]     x_pos;
  logic [DIM_W-1:0]     y_pos;
  logic                 line_done;
  logic                 frame_done;
  logic                 busy;
  logic [2*DIM_W-1:0]   pixel_count;
  logic [pixel_pkg::CHECKSUM_W-1:0] checksum;
  logic                 overflow;

  modport master (
    output start, size_x, size_y, pixel_in, pixel_valid,
    input  x_pos, y_pos, line_done, frame_done, busy, pixel_count, checksum, overflow
  );

  modport slave (
    input  start, size_x, size_y, pixel_in, pixel_valid,
    output x_pos, y_pos, line_done, frame_done, busy, pixel_count, checksum, overflow
  );

endinterface

// File: rtl/pixel_coord_counter.sv
// Raster x/y position counter with programmable line length and line count.
module pixel_coord_counter #(
  parameter int DIM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [DIM_W-1:0] size_x_i,
  input  logic [DIM_W-1:0] size_y_i,
  output logic [DIM_W-1:0] x_pos_o,
  output logic [DIM_W-1:0] y_pos_o,
  output logic             line_wrap_o,
  output logic             last_o
);

  logic [DIM_W-1:0] x_q;
  logic [DIM_W-1:0] y_q;
  logic             x_at_end;
  logic             y_at_end;

  assign x_at_end = (x_q == size_x_i - DIM_W'(1));
  assign y_at_end = (y_q == size_y_i - DIM_W'(1));

  assign line_wrap_o = advance_i & x_at_end;
  assign last_o      = x_at_end & y_at_end;
  assign x_pos_o     = x_q;
  assign y_pos_o     = y_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clear_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance_i) begin
      if (x_at_end) begin
        x_q <= '0;
        y_q <= y_at_end ? '0 : y_q + DIM_W'(1);
      end else begin
        x_q <= x_q + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_frame_collector.sv
// Frame sink: tracks pixel position, accumulates a checksum and flags stray pixels.
module pixel_frame_collector #(
  parameter int PIXEL_W = 8,
  parameter int DIM_W   = pixel_pkg::DIM_W
) (
  input logic                     clk,
  input logic                     rst,
  pixel_frame_collector_if.slave  bus
);

  import pixel_pkg::*;

  localparam int CNT_W = 2 * DIM_W;

  t_collector_state        state_q, state_d;
  logic [DIM_W-1:0]        size_x_q, size_x_d;
  logic [DIM_W-1:0]        size_y_q, size_y_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CHECKSUM_W-1:0]   checksum_q, checksum_d;
  logic                    overflow_q, overflow_d;
  logic                    line_done_q, line_done_d;

  logic                    coord_clear;
  logic                    coord_advance;
  logic                    coord_line_wrap;
  logic                    coord_last;
  logic [DIM_W-1:0]        x_pos;
  logic [DIM_W-1:0]        y_pos;
  logic [CNT_W-1:0]        frame_total;
  logic [CNT_W-1:0]        count_inc;

  // Full-width product so large frames never wrap the pixel total.
  assign frame_total = {{DIM_W{1'b0}}, size_x_q} * {{DIM_W{1'b0}}, size_y_q};
  assign count_inc   = count_q + CNT_W'(1);

  pixel_coord_counter #(.DIM_W(DIM_W)) u_coord (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (coord_clear),
    .advance_i  (coord_advance),
    .size_x_i   (size_x_q),
    .size_y_i   (size_y_q),
    .x_pos_o    (x_pos),
    .y_pos_o    (y_pos),
    .line_wrap_o(coord_line_wrap),
    .last_o     (coord_last)
  );

  always_comb begin
    state_d       = state_q;
    size_x_d      = size_x_q;
    size_y_d      = size_y_q;
    count_d       = count_q;
    checksum_d    = checksum_q;
    overflow_d    = overflow_q;
    line_done_d   = 1'b0;
    coord_clear   = 1'b0;
    coord_advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          size_x_d    = bus.size_x;
          size_y_d    = bus.size_y;
          count_d     = '0;
          checksum_d  = '0;
          overflow_d  = 1'b0;
          coord_clear = 1'b1;
          state_d     = (bus.size_x == '0 || bus.size_y == '0) ? DONE : COLLECT;
        end
        // A stray pixel in the arming cycle still counts as an error.
        if (bus.pixel_valid) begin
          overflow_d = 1'b1;
        end
      end
      COLLECT: begin
        if (bus.pixel_valid) begin
          coord_advance = 1'b1;
          count_d       = count_inc;
          checksum_d    = checksum_step(checksum_q, CHECKSUM_W'(bus.pixel_in));
          line_done_d   = coord_line_wrap;
          // The coordinate corner and the count total agree for any nonzero geometry.
          if (coord_last && count_inc == frame_total) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (bus.pixel_valid) begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      size_x_q    <= '0;
      size_y_q    <= '0;
      count_q     <= '0;
      checksum_q  <= '0;
      overflow_q  <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_x_q    <= size_x_d;
      size_y_q    <= size_y_d;
      count_q     <= count_d;
      checksum_q  <= checksum_d;
      overflow_q  <= overflow_d;
      line_done_q <= line_done_d;
    end
  end

  assign bus.x_pos       = x_pos;
  assign bus.y_pos       = y_pos;
  assign bus.line_done   = line_done_q;
  assign bus.frame_done  = (state_q == DONE);
  assign bus.busy        = (state_q == COLLECT);
  assign bus.pixel_count = count_q;
  assign bus.checksum    = checksum_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_pixel_frame_collector.sv
// Scoreboard bench for pixel_frame_collector: per-cycle expected outputs from a reference model.
module tb_pixel_frame_collector;

  logic clk;
  logic rst;

  pixel_frame_collector_if #(.PIXEL_W(8), .DIM_W(12)) bus ();

  pixel_frame_collector #(.PIXEL_W(8), .DIM_W(12)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    int          cnt;
    logic [31:0] chk;
    logic        ovf;
    logic        ld;
    logic        fd;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int frames_exp = 0;
  int frames_seen = 0;

  // Reference model state: 0 idle, 1 collecting, 2 done
  int          m_st;
  int          m_sx, m_sy;
  int          m_x, m_y, m_cnt;
  logic [31:0] m_chk;
  logic        m_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check_val("x_pos",       32'(bus.x_pos),       32'(e.x));
    check_val("y_pos",       32'(bus.y_pos),       32'(e.y));
    check_val("pixel_count", 32'(bus.pixel_count), 32'(e.cnt));
    check_val("checksum",    bus.checksum,         e.chk);
    check_val("overflow",    32'(bus.overflow),    32'(e.ovf));
    check_val("line_done",   32'(bus.line_done),   32'(e.ld));
    check_val("frame_done",  32'(bus.frame_done),  32'(e.fd));
    check_val("busy",        32'(bus.busy),        32'(e.busy));
    if (e.fd) frames_exp++;
    if (bus.frame_done) begin
      frames_seen++;
      $display("frame done: count=%0d checksum=%h overflow=%0b",
               bus.pixel_count, bus.checksum, bus.overflow);
    end
  endtask

  task automatic cyc(input logic s, input logic v, input logic [7:0] p);
    exp_t e;
    logic ld;
    bus.start       = s;
    bus.pixel_valid = v;
    bus.pixel_in    = p;
    ld = 1'b0;
    case (m_st)
      0: begin
        if (s) begin
          m_sx  = int'(bus.size_x);
          m_sy  = int'(bus.size_y);
          m_cnt = 0;
          m_chk = '0;
          m_x   = 0;
          m_y   = 0;
          m_ovf = 1'b0;
          m_st  = (m_sx == 0 || m_sy == 0) ? 2 : 1;
        end
        if (v) m_ovf = 1'b1;
      end
      1: begin
        if (v) begin
          m_chk = {m_chk[30:0], m_chk[31]} ^ {24'h0, p};
          m_cnt++;
          ld = ((m_cnt % m_sx) == 0);
          if (m_cnt == m_sx * m_sy) begin
            m_x  = 0;
            m_y  = 0;
            m_st = 2;
          end else begin
            m_x = m_cnt % m_sx;
            m_y = m_cnt / m_sx;
          end
        end
      end
      default: begin
        m_st = 0;
        if (v) m_ovf = 1'b1;
      end
    endcase
    e.x = m_x; e.y = m_y; e.cnt = m_cnt; e.chk = m_chk; e.ovf = m_ovf;
    e.ld = ld; e.fd = (m_st == 2); e.busy = (m_st == 1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic rst_cycle();
    exp_t e;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in = '0;
    m_st = 0; m_sx = 0; m_sy = 0; m_x = 0; m_y = 0; m_cnt = 0; m_chk = '0; m_ovf = 1'b0;
    e.x = 0; e.y = 0; e.cnt = 0; e.chk = '0; e.ovf = 1'b0; e.ld = 1'b0; e.fd = 1'b0; e.busy = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
    rst = 1'b1;
  endtask

  task automatic run_frame_2x2(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
    bus.size_x = 12'd2;
    bus.size_y = 12'd2;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, a);
    cyc(1'b0, 1'b1, b);
    cyc(1'b0, 1'b1, c);
    cyc(1'b0, 1'b1, d);
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in = '0;
    bus.size_x = '0;
    bus.size_y = '0;
    rst_cycle();
    rst_cycle();

    // Reference 2x2 frame
    run_frame_2x2(8'h01, 8'h02, 8'h03, 8'h04);
    check_val("chk_2x2", bus.checksum, 32'h0000_0002);
    check_val("cnt_2x2", 32'(bus.pixel_count), 32'd4);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // Order sensitivity
    run_frame_2x2(8'h02, 8'h01, 8'h03, 8'h04);
    check_val("chk_swap", bus.checksum, 32'h0000_0016);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // 4x3 with gaps; a start during collection must be ignored
    bus.size_x = 12'd4;
    bus.size_y = 12'd3;
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b1, 8'(i));
      if (i < 12) cyc(i == 5, 1'b0, 8'h00);
    end
    check_val("cnt_4x3", 32'(bus.pixel_count), 32'd12);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // Stray pixels in IDLE and DONE
    cyc(1'b0, 1'b1, 8'hAA);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hBB);
    run_frame_2x2(8'h10, 8'h20, 8'h30, 8'h40);
    cyc(1'b0, 1'b1, 8'h55);
    check_val("ovf_done", 32'(bus.overflow), 32'd1);
    cyc(1'b0, 1'b1, 8'h66);
    cyc(1'b0, 1'b0, 8'h00);
    check_val("cnt_hold", 32'(bus.pixel_count), 32'd4);

    // Start clears overflow, then start+valid arms with overflow set
    run_frame_2x2(8'h01, 8'h01, 8'h01, 8'h01);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    bus.size_x = 12'd2;
    bus.size_y = 12'd2;
    cyc(1'b1, 1'b1, 8'h77);
    check_val("ovf_start_valid", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'hC0 + i));
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // Zero-size frame goes straight to DONE
    bus.size_x = 12'd0;
    bus.size_y = 12'd40;
    cyc(1'b1, 1'b0, 8'h00);
    check_val("zero_fd", 32'(bus.frame_done), 32'd1);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // 40x40 aborted by reset, then a full frame
    bus.size_x = 12'd40;
    bus.size_y = 12'd40;
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 700; i++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    rst_cycle();
    cyc(1'b0, 1'b0, 8'h00);
    bus.size_x = 12'd40;
    bus.size_y = 12'd40;
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 1600; i++) begin
      cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)));
      if (i % 97 == 3) cyc(1'b0, 1'b0, 8'h00);
    end
    check_val("cnt_40x40", 32'(bus.pixel_count), 32'd1600);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    check_val("frame_done_total", 32'(frames_seen), 32'(frames_exp));
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
